// File: rtl/shift_reg_pkg.sv
// Shared types and the next-value function for the universal shift register.
// shift_next works on a MAX_W-wide container so one function serves every WIDTH.
package shift_reg_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    SHL = 2'd0,
    SHR = 2'd1,
    ROL = 2'd2,
    ROR = 2'd3
  } shift_mode_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // r holds a w-bit value in its low bits; bits at w and above are ignored.
  // The result has those upper bits cleared.
  function automatic logic [MAX_W-1:0] shift_next(input logic [MAX_W-1:0] r,
                                                  input int unsigned     w,
                                                  input shift_mode_e     mode,
                                                  input logic            serial_in);
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] top;
    logic [MAX_W-1:0] res;
    logic             msb;
    logic             fill_l;
    logic             fill_r;
    mask   = (MAX_W'(1) << w) - MAX_W'(1);
    top    = MAX_W'(1) << (w - 1);
    msb    = |(r & top);
    fill_l = (mode == SHL) ? serial_in : msb;
    fill_r = (mode == SHR) ? serial_in : r[0];
    if (mode == SHL || mode == ROL) begin
      res = ((r << 1) | MAX_W'(fill_l)) & mask;
    end else begin
      res = ((r & mask) >> 1) | (fill_r ? top : '0);
    end
    return res;
  endfunction

endpackage

// File: rtl/univ_shift_reg.sv
// Universal shift register with parallel load and a start/count burst engine.
// WIDTH must not exceed shift_reg_pkg::MAX_W.
module univ_shift_reg
  import shift_reg_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [WIDTH-1:0]  parallel_data_in,
  input  shift_mode_e       mode,
  input  logic              start,
  input  logic [CNT_W-1:0]  shift_count,
  input  logic              serial_in,
  output logic [WIDTH-1:0]  parallel_data_out,
  output logic              serial_out,
  output logic              busy,
  output logic              done
);

  state_e            state_q, state_d;
  shift_mode_e       mode_q, mode_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  shifted;
  logic [CNT_W-1:0]  count_sat;

  assign shifted   = WIDTH'(shift_next(MAX_W'(data_q), WIDTH, mode_q, serial_in));
  assign count_sat = (shift_count > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : shift_count;

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    data_d      = data_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          data_d = parallel_data_in;
        end else if (start) begin
          // A zero-length burst completes immediately without entering SHIFT.
          if (shift_count != '0) begin
            mode_d      = mode;
            remaining_d = count_sat;
            state_d     = SHIFT;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        data_d      = shifted;
        remaining_d = remaining_q - CNT_W'(1);
        if (remaining_q == CNT_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      mode_q      <= SHL;
      data_q      <= RESET_VAL;
      remaining_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      data_q      <= data_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
    end
  end

  assign parallel_data_out = data_q;
  assign serial_out        = (mode_q == SHL || mode_q == ROL) ? data_q[WIDTH-1] : data_q[0];
  assign busy              = (state_q == SHIFT);
  assign done              = done_q;

endmodule
